alu_arbiter: RTL and testbench

- Shares the single combinational 16-bit ALU between two requesters, e.g. the issue stage and the address-generation unit.
- Round-robin grant; accepts one operation at a time and drives the ALU control and operand ports from registered copies.
- Captures the ALU result into a register and returns it with the requester ID over a valid/ready response channel.
- Sits between the requesters and the ALU instance in the datapath.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional result flags (zero/neg/parity) are enabled by defining ALU_FLAGS_EN.
module alu_arbiter #(
    parameter int DW = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [CW-1:0] req0_ctrl,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [CW-1:0] req1_ctrl,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic [CW-1:0] alu_ctrl,
    output logic [DW-1:0] alu_din1,
    output logic [DW-1:0] alu_din2,
    input  logic [DW-1:0] alu_dout,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_id,
    output logic [DW-1:0] resp_data,
    output logic          busy
`ifdef ALU_FLAGS_EN
    ,
    output logic          resp_zero,
    output logic          resp_neg,
    output logic          resp_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    state_e        state_q;
    logic          last_grant_q;
    logic [CW-1:0] ctrl_q;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic          id_q;
    logic [DW-1:0] data_q;
    logic          resp_valid_q;
    logic          busy_q;
    logic          grant;
    logic          accept;
`ifdef ALU_FLAGS_EN
    logic          zero_q;
    logic          neg_q;
    logic          parity_q;
`endif

    // With both valid, the requester not served last time wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && !grant && req0_valid;
    assign req1_ready = (state_q == IDLE) &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            ctrl_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ALU_FLAGS_EN
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            parity_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ctrl_q       <= grant ? req1_ctrl : req0_ctrl;
                        a_q          <= grant ? req1_a    : req0_a;
                        b_q          <= grant ? req1_b    : req0_b;
                        id_q         <= grant;
                        last_grant_q <= grant;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    data_q       <= alu_dout;
`ifdef ALU_FLAGS_EN
                    zero_q       <= (alu_dout == '0);
                    neg_q        <= alu_dout[DW-1];
                    parity_q     <= ^alu_dout;
`endif
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign alu_ctrl   = ctrl_q;
    assign alu_din1   = a_q;
    assign alu_din2   = b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign busy       = busy_q;
`ifdef ALU_FLAGS_EN
    assign resp_zero   = zero_q;
    assign resp_neg    = neg_q;
    assign resp_parity = parity_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a small behavioural ALU (1=add, 2=sub, else din1).
// Flag outputs are checked only when ALU_FLAGS_EN is defined.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl, alu_ctrl;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] alu_din1, alu_din2, alu_dout, resp_data;
    logic        resp_valid, resp_ready, resp_id, busy;
`ifdef ALU_FLAGS_EN
    logic        resp_zero, resp_neg, resp_parity;
`endif

    typedef struct packed {
        logic        id;
        logic        zero;
        logic        neg;
        logic        par;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_dout = alu_din1;
        case (alu_ctrl)
            4'd1:    alu_dout = alu_din1 + alu_din2;
            4'd2:    alu_dout = alu_din1 - alu_din2;
            default: alu_dout = alu_din1;
        endcase
    end

    alu_arbiter #(.DW(16), .CW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_ctrl   (alu_ctrl),
        .alu_din1   (alu_din1),
        .alu_din2   (alu_din2),
        .alu_dout   (alu_dout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
`ifdef ALU_FLAGS_EN
        ,
        .resp_zero  (resp_zero),
        .resp_neg   (resp_neg),
        .resp_parity(resp_parity)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [15:0] data,
                        input logic zero, input logic neg, input logic par);
        exp_t e;
        e.id = id; e.data = data; e.zero = zero; e.neg = neg; e.par = par;
        sb_q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every completed response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got id=%0d data=0x%0h, expected no response",
                         resp_id, resp_data);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_data", {16'h0, resp_data}, {16'h0, mon_e.data});
                check("resp_id", {31'h0, resp_id}, {31'h0, mon_e.id});
`ifdef ALU_FLAGS_EN
                check("resp_zero", {31'h0, resp_zero}, {31'h0, mon_e.zero});
                check("resp_neg", {31'h0, resp_neg}, {31'h0, mon_e.neg});
                check("resp_parity", {31'h0, resp_parity}, {31'h0, mon_e.par});
`endif
            end
        end
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b0;

        // Reset state
        sample();
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_resp_data", {16'h0, resp_data}, 32'h0);
        check("rst_alu_ctrl", {28'h0, alu_ctrl}, 32'h0);
        check("rst_alu_din1", {16'h0, alu_din1}, 32'h0);

        // Single add from req0
        reset_dut();
        req0_valid = 1'b1; req0_ctrl = 4'd1; req0_a = 16'h0003; req0_b = 16'h0004;
        resp_ready = 1'b1;
        sample();
        check("t1_req0_ready", {31'h0, req0_ready}, 32'h1);
        check("t1_req1_ready", {31'h0, req1_ready}, 32'h0);
        push(1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);
        next();
        req0_valid = 1'b0;
        sample();
        check("t1_alu_ctrl", {28'h0, alu_ctrl}, 32'h1);
        check("t1_alu_din1", {16'h0, alu_din1}, 32'h3);
        check("t1_alu_din2", {16'h0, alu_din2}, 32'h4);
        check("t1_busy_exec", {31'h0, busy}, 32'h1);
        check("t1_no_early_valid", {31'h0, resp_valid}, 32'h0);
        next();
        sample();
        check("t1_resp_valid", {31'h0, resp_valid}, 32'h1);
        next();
        sample();
        check("t1_busy_done", {31'h0, busy}, 32'h0);
        check("t1_valid_done", {31'h0, resp_valid}, 32'h0);

        // Both requesters continuously valid: alternate 0,1,0,1 every 3 cycles
        reset_dut();
        req0_valid = 1'b1; req0_ctrl = 4'd1; req0_a = 16'd10; req0_b = 16'd1;
        req1_valid = 1'b1; req1_ctrl = 4'd2; req1_a = 16'd10; req1_b = 16'd1;
        resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sample();
            if (k % 3 == 0) begin
                if ((k / 3) % 2 == 0) begin
                    check("t2_r0_grant", {31'h0, req0_ready}, 32'h1);
                    check("t2_r1_idle", {31'h0, req1_ready}, 32'h0);
                    push(1'b0, 16'd11, 1'b0, 1'b0, 1'b1);
                end else begin
                    check("t2_r0_idle", {31'h0, req0_ready}, 32'h0);
                    check("t2_r1_grant", {31'h0, req1_ready}, 32'h1);
                    push(1'b1, 16'd9, 1'b0, 1'b0, 1'b0);
                end
            end else begin
                check("t2_r0_blocked", {31'h0, req0_ready}, 32'h0);
                check("t2_r1_blocked", {31'h0, req1_ready}, 32'h0);
                check("t2_resp_valid", {31'h0, resp_valid}, (k % 3 == 2) ? 32'h1 : 32'h0);
            end
            next();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        check("t2_idle_after", {31'h0, busy}, 32'h0);
        next();

        // Backpressure: req1 sub 0-1 held for 5 cycles
        req1_valid = 1'b1; req1_ctrl = 4'd2; req1_a = 16'h0000; req1_b = 16'h0001;
        resp_ready = 1'b0;
        sample();
        check("t3_r1_accept", {31'h0, req1_ready}, 32'h1);
        check("t3_r0_none", {31'h0, req0_ready}, 32'h0);
        push(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        next();
        req1_valid = 1'b0;
        req0_ctrl = 4'd2; req0_a = 16'h1234; req0_b = 16'h1234;
        sample();
        check("t3_alu_ctrl", {28'h0, alu_ctrl}, 32'h2);
        check("t3_alu_din2", {16'h0, alu_din2}, 32'h1);
        next();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            check("t3_hold_valid", {31'h0, resp_valid}, 32'h1);
            check("t3_hold_data", {16'h0, resp_data}, 32'hFFFF);
            check("t3_hold_id", {31'h0, resp_id}, 32'h1);
            check("t3_hold_r0", {31'h0, req0_ready}, 32'h0);
            check("t3_hold_r1", {31'h0, req1_ready}, 32'h0);
`ifdef ALU_FLAGS_EN
            check("t3_hold_neg", {31'h0, resp_neg}, 32'h1);
            check("t3_hold_zero", {31'h0, resp_zero}, 32'h0);
            check("t3_hold_par", {31'h0, resp_parity}, 32'h0);
`endif
            next();
        end
        resp_ready = 1'b1;
        sample();
        check("t3_release_r0", {31'h0, req0_ready}, 32'h0);
        next();
        sample();
        check("t3_resume_r0", {31'h0, req0_ready}, 32'h1);
        check("t3_resume_r1", {31'h0, req1_ready}, 32'h0);
        push(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        next();
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        next();
        sample();
        check("t4_resp_valid", {31'h0, resp_valid}, 32'h1);
        next();
        sample();
        check("t4_busy_done", {31'h0, busy}, 32'h0);
        next();

        // Reset during EXEC aborts the operation
        req1_valid = 1'b1; req1_ctrl = 4'd1; req1_a = 16'd5; req1_b = 16'd5;
        sample();
        check("t5_r1_accept", {31'h0, req1_ready}, 32'h1);
        next();
        req1_valid = 1'b0;
        sample();
        check("t5_busy_exec", {31'h0, busy}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_busy", {31'h0, busy}, 32'h0);
        check("t5_async_valid", {31'h0, resp_valid}, 32'h0);
        check("t5_async_ctrl", {28'h0, alu_ctrl}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 4'hF; req0_a = 16'hABCD; req0_b = 16'h1111;
        req1_valid = 1'b1; req1_ctrl = 4'd1; req1_a = 16'hFFFF; req1_b = 16'h0001;
        resp_ready = 1'b0;
        sample();
        check("t5_first_r0", {31'h0, req0_ready}, 32'h1);
        check("t5_first_r1", {31'h0, req1_ready}, 32'h0);
        push(1'b0, 16'hABCD, 1'b0, 1'b1, 1'b0);
        next();
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        check("t5_unknown_ctrl", {28'h0, alu_ctrl}, 32'hF);
        next();

        // req0 pulse during pending RESP is ignored
        req0_valid = 1'b1;
        sample();
        check("t6_pulse_r0", {31'h0, req0_ready}, 32'h0);
        check("t6_pulse_valid", {31'h0, resp_valid}, 32'h1);
        next();
        req0_valid = 1'b0;
        sample();
        check("t6_after_r0", {31'h0, req0_ready}, 32'h0);
        check("t6_after_r1", {31'h0, req1_ready}, 32'h0);
        next();
        resp_ready = 1'b1;
        sample();
        next();
        req0_valid = 1'b1; req1_valid = 1'b1;
        sample();
        check("t6_rr_r1", {31'h0, req1_ready}, 32'h1);
        check("t6_rr_r0", {31'h0, req0_ready}, 32'h0);
        push(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        next();
        req0_valid = 1'b0; req1_valid = 1'b0;
        sample();
        next();
        sample();
        check("t6_resp_valid", {31'h0, resp_valid}, 32'h1);
        next();
        sample();
        check("t6_valid_done", {31'h0, resp_valid}, 32'h0);
        check("t6_busy_done", {31'h0, busy}, 32'h0);
        next();
        next();
        sample();
        check("sb_empty", sb_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
